rx_oversampler: RTL

Parametrised UART receive front end for the WBUART receive path. It synchronises the serial input and detects a start bit with glitch rejection. Each bit is sampled with 3-point majority voting, and data length, parity and stop-bit count are runtime-configurable. It delivers an aligned data word with parity, frame, noise and break flags as a one-cycle valid pulse to the receive FIFO/register logic.

---
 rtl/rx_oversampler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rx_oversampler.sv
// rx_oversampler: UART receive front end with 3-point majority sampling and runtime frame format
module rx_oversampler #(
  parameter int MAX_DATA_BITS = 9,
  parameter int SYNC_STAGES   = 3,
  parameter int CLK_DIV_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CLK_DIV_WIDTH-1:0] cr_clk_div_i,
  input  logic [2:0]               cr_ds_i,
  input  logic [1:0]               cr_p_i,
  input  logic                     cr_s_i,
  input  logic                     uart_rx_i,
  output logic [MAX_DATA_BITS-1:0] data_o,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     noise_err_o,
  output logic                     break_o,
  output logic                     output_valid_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_e;
  localparam logic [CLK_DIV_WIDTH-1:0] ONE = 1;
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CLK_DIV_WIDTH-1:0] div_q, div_d, p_q, p_d, half;
  logic [3:0] n_q, n_d, idx_q, idx_d, n_raw, n_cfg;
  logic [1:0] pm_q, pm_d;
  logic two_q, two_d, s0_q, s0_d, s1_q, s1_d;
  logic par_acc_q, par_acc_d, perr_q, perr_d, noise_q, noise_d, frame_q, frame_d, zero_q, zero_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic perr_o_q, perr_o_d, ferr_o_q, ferr_o_d, noise_o_q, noise_o_d, brk_o_q, brk_o_d, valid_q, valid_d;
  logic rx_s, eval, wrap, maj, noisy, zero_n;
  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign half   = div_q >> 1;
  assign eval   = p_q == half + ONE;
  assign wrap   = p_q == div_q - ONE;
  assign maj    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign noisy  = (s0_q ^ s1_q) | (s1_q ^ rx_s);
  assign zero_n = (idx_q == 4'd0) ? zero_q & ~maj : zero_q;
  assign n_raw  = 4'd5 + {1'b0, cr_ds_i};
  assign n_cfg  = (n_raw > 4'(MAX_DATA_BITS)) ? 4'(MAX_DATA_BITS) : n_raw;
  assign data_o         = data_q;
  assign parity_err_o   = perr_o_q;
  assign frame_err_o    = ferr_o_q;
  assign noise_err_o    = noise_o_q;
  assign break_o        = brk_o_q;
  assign output_valid_o = valid_q;
  // Input synchroniser; resets to the idle-high line level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
  end
  // Frame sequencing, bit timing, majority voting and result capture
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    n_d       = n_q;
    idx_d     = idx_q;
    pm_d      = pm_q;
    two_d     = two_q;
    s0_d      = (p_q == half - ONE) ? rx_s : s0_q;
    s1_d      = (p_q == half) ? rx_s : s1_q;
    p_d       = (wrap || state_q == IDLE || state_q == WAIT_IDLE) ? '0 : p_q + ONE;
    par_acc_d = par_acc_q;
    perr_d    = perr_q;
    noise_d   = (eval && state_q != IDLE && state_q != WAIT_IDLE) ? noise_q | noisy : noise_q;
    frame_d   = frame_q;
    zero_d    = zero_q;
    shift_d   = shift_q;
    data_d    = data_q;
    perr_o_d  = perr_o_q;
    ferr_o_d  = ferr_o_q;
    noise_o_d = noise_o_q;
    brk_o_d   = brk_o_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: if (!rx_s && !valid_q) begin
        state_d   = START;
        div_d     = cr_clk_div_i;
        n_d       = n_cfg;
        pm_d      = cr_p_i;
        two_d     = cr_s_i;
        idx_d     = '0;
        shift_d   = '0;
        par_acc_d = cr_p_i[0];
        perr_d    = 1'b0;
        noise_d   = 1'b0;
        frame_d   = 1'b0;
        zero_d    = 1'b1;
      end
      START: begin
        if (eval && maj) state_d = IDLE;
        else if (wrap) state_d = DATA;
      end
      DATA: begin
        if (eval) begin
          shift_d   = {maj, shift_q[MAX_DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ maj;
          zero_d    = zero_q & ~maj;
        end
        if (wrap) begin
          idx_d   = (idx_q == n_q - 4'd1) ? 4'd0 : idx_q + 4'd1;
          state_d = (idx_q != n_q - 4'd1) ? DATA : (pm_q != 2'b00) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (eval) begin
          perr_d = maj ^ par_acc_q;
          zero_d = zero_q & ~maj;
        end
        if (wrap) state_d = STOP;
      end
      STOP: begin
        if (eval) begin
          frame_d = frame_q | ~maj;
          zero_d  = zero_n;
          if (idx_q == {3'b000, two_q}) begin
            valid_d   = 1'b1;
            data_d    = shift_q >> (4'(MAX_DATA_BITS) - n_q);
            perr_o_d  = perr_q;
            ferr_o_d  = frame_q | ~maj;
            noise_o_d = noise_q | noisy;
            brk_o_d   = zero_n;
            state_d   = maj ? IDLE : WAIT_IDLE;
          end
        end
        if (wrap) idx_d = idx_q + 4'd1;
      end
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      div_q     <= '0;
      p_q       <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      pm_q      <= '0;
      two_q     <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      par_acc_q <= 1'b0;
      perr_q    <= 1'b0;
      noise_q   <= 1'b0;
      frame_q   <= 1'b0;
      zero_q    <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      perr_o_q  <= 1'b0;
      ferr_o_q  <= 1'b0;
      noise_o_q <= 1'b0;
      brk_o_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      p_q       <= p_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      pm_q      <= pm_d;
      two_q     <= two_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      par_acc_q <= par_acc_d;
      perr_q    <= perr_d;
      noise_q   <= noise_d;
      frame_q   <= frame_d;
      zero_q    <= zero_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      perr_o_q  <= perr_o_d;
      ferr_o_q  <= ferr_o_d;
      noise_o_q <= noise_o_d;
      brk_o_q   <= brk_o_d;
      valid_q   <= valid_d;
    end
  end
endmodule
